// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the RV32I datapath.
// Owns the fetch PC, issues word reads to instruction memory over a
// req/ack handshake and buffers returned words with their PCs in a small
// FIFO that decode drains through inst_valid/inst_ready.
// Optional feature: define FETCH_PERF_EN to add the perf_stall_cnt output,
// a free-running count of cycles where decode was ready but nothing was valid.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // KILL is a request still on the bus whose data belongs to a flushed path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetchState_e;

  fetchState_e state_q, state_d;

  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] reqAddr_q, reqAddr_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]      headData_q, headData_d;
  logic [31:0]      headPc_q, headPc_d;

  logic [31:0] memData_q [DEPTH];
  logic [31:0] memPc_q   [DEPTH];

  logic             pushEn;
  logic             popEn;
  logic             slotFree;
  logic             newReq;
  logic [CNT_W-1:0] countAfterPop;

  // Handshake qualifiers: only a live (non-killed) request may push, and a
  // redirect in the same cycle drops both the returning word and any pop.
  always_comb begin
    pushEn = (state_q == REQ) && imem_ack && !redirect;
    popEn  = (count_q != '0) && inst_ready && !redirect;
  end

  // Fetch PC: redirect wins, otherwise advance by one word per accepted push.
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (redirect) begin
      fetchPc_d = redirect_pc & ~32'h3;
    end else if (pushEn) begin
      fetchPc_d = fetchPc_q + 32'd4;
    end
  end

  // FIFO pointer/count bookkeeping and the registered head view for decode.
  always_comb begin
    count_d       = count_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    headData_d    = headData_q;
    headPc_d      = headPc_q;
    countAfterPop = count_q - CNT_W'(popEn);
    if (redirect) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      count_d = countAfterPop + CNT_W'(pushEn);
      if (pushEn && (countAfterPop == '0)) begin
        headData_d = imem_rdata;
        headPc_d   = fetchPc_q;
      end else if (popEn && (countAfterPop != '0)) begin
        headData_d = memData_q[rdPtr_d];
        headPc_d   = memPc_q[rdPtr_d];
      end
    end
  end

  // A slot is free when the FIFO will not be full next cycle; the bus is
  // idle whenever this is evaluated, so no outstanding term is needed.
  always_comb begin
    slotFree = (count_d < CNT_W'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: requests hold until ack; a redirect during a pending
  // request turns it into a kill so its data is thrown away on arrival.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = slotFree ? REQ : IDLE;
      end
      REQ: begin
        if (imem_ack) begin
          state_d = slotFree ? REQ : IDLE;
        end else if (redirect) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (imem_ack) begin
          state_d = slotFree ? REQ : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: the bus request is up in both REQ and KILL.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      REQ, KILL: imem_req = 1'b1;
      default:   imem_req = 1'b0;
    endcase
  end

  // A fresh request starts when entering REQ from idle or right after an ack;
  // its address is captured so the bus stays stable while fetchPc moves.
  always_comb begin
    newReq    = (state_d == REQ) && ((state_q == IDLE) || imem_ack);
    reqAddr_d = newReq ? fetchPc_d : reqAddr_q;
  end

  // Datapath registers: fetch PC, request address, FIFO control and head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      reqAddr_q  <= RESET_PC;
      count_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      headData_q <= '0;
      headPc_q   <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      reqAddr_q  <= reqAddr_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      headData_q <= headData_d;
      headPc_q   <= headPc_d;
    end
  end

  // FIFO storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memData_q[wrPtr_q] <= imem_rdata;
      memPc_q[wrPtr_q]   <= fetchPc_q;
    end
  end

  // Output drive from registered state.
  always_comb begin
    imem_addr  = reqAddr_q;
    inst_valid = (count_q != '0);
    inst_data  = headData_q;
    inst_pc    = headPc_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perfStall_q;

  // Stall counter: decode wanted an instruction and none was available.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfStall_q <= '0;
    end else if (inst_ready && !inst_valid) begin
      perfStall_q <= perfStall_q + 32'd1;
    end
  end

  // Counter exposed directly.
  always_comb begin
    perf_stall_cnt = perfStall_q;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Vector table for the basic streaming/redirect/wrap sequences, hand-written
// sequences for kill and reset-mid-request, and a randomized run checked
// against a stream-level reference model. Define FETCH_PERF_EN to also
// exercise perf_stall_cnt.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state (stream level).
  int          mCount;
  logic [31:0] mFetch;
  logic [31:0] mPopPc;
  logic        mKill;
  logic        mHeld;
  logic [31:0] mHeldAddr;
  logic        mStarted;
  logic [31:0] mStall;

  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        expReq;
    logic        chkAddr;
    logic [31:0] expAddr;
    logic        expValid;
    logic        chkPc;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs [16];

  fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memFunc(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
    imem_ack    = ack;
    inst_ready  = ready;
    redirect    = redir;
    redirect_pc = rpc;
    imem_rdata  = memFunc(imem_addr);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with rst just released (cycle 0).
  task automatic resetDut(input logic ackDuring);
    rst         = 1'b1;
    imem_ack    = ackDuring;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic modelReset();
    mCount    = 0;
    mFetch    = RESET_PC;
    mPopPc    = RESET_PC;
    mKill     = 1'b0;
    mHeld     = 1'b0;
    mHeldAddr = '0;
    mStarted  = 1'b0;
    mStall    = '0;
  endtask

  // One cycle against the reference model: drive, check, advance model.
  task automatic modelCycle(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
    logic        eReq;
    logic        pushE;
    logic        popE;
    logic [31:0] target;
    applyStimulus(ack, ready, redir, rpc);
    eReq = mStarted && (mHeld || (mCount < int'(DEPTH)));
    checkOutput("m valid", {31'b0, inst_valid}, {31'b0, (mCount != 0)});
    checkOutput("m req", {31'b0, imem_req}, {31'b0, eReq});
    if (mHeld) checkOutput("m addrHold", imem_addr, mHeldAddr);
    if (eReq && ack && !mKill) checkOutput("m reqAddr", imem_addr, mFetch);
    popE = ready && (mCount != 0) && !redir;
    if (popE) begin
      checkOutput("m popPc", inst_pc, mPopPc);
      checkOutput("m popData", inst_data, memFunc(mPopPc));
    end
`ifdef FETCH_PERF_EN
    checkOutput("m perf", perf_stall_cnt, mStall);
    if (ready && (mCount == 0)) mStall = mStall + 32'd1;
`endif
    target    = rpc & ~32'h3;
    pushE     = eReq && ack && !mKill && !redir;
    mCount    = redir ? 0 : (mCount + int'(pushE) - int'(popE));
    mFetch    = redir ? target : (pushE ? mFetch + 32'd4 : mFetch);
    mPopPc    = redir ? target : (popE ? mPopPc + 32'd4 : mPopPc);
    mKill     = (eReq && ack) ? 1'b0 : (mKill || (redir && eReq));
    mHeld     = eReq && !ack;
    mHeldAddr = imem_addr;
    mStarted  = 1'b1;
    step();
  endtask

  initial begin
    logic        a;
    logic        r;
    logic        d;
    logic [31:0] p;
    int          reqAge;

    // ack, ready, redir, rpc | expReq, chkAddr, expAddr, expValid, chkPc, expPc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 1'b1, 32'h8};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h203,      1'b1, 1'b1, 32'h10,       1'b1, 1'b1, 32'hC};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h204,      1'b1, 1'b1, 32'h200};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 1'b1, 32'h4};

    $display("[TB] vector table: streaming, full FIFO, redirect with ack+pop, PC wrap");
    resetDut(1'b0);
    checkOutput("reset data", inst_data, 32'h0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      checkOutput($sformatf("row%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      if (vecs[i].chkAddr) checkOutput($sformatf("row%0d addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("row%0d valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].expValid});
      if (vecs[i].chkPc) checkOutput($sformatf("row%0d pc", i), inst_pc, vecs[i].expPc);
      if (vecs[i].expValid) checkOutput($sformatf("row%0d data", i), inst_data, memFunc(vecs[i].expPc));
      step();
    end

    $display("[TB] kill sequence: redirect while request waits for ack");
    resetDut(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("kill c0 req", {31'b0, imem_req}, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    checkOutput("kill c1 req", {31'b0, imem_req}, 32'h1);
    checkOutput("kill c1 addr", imem_addr, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("kill c2 req", {31'b0, imem_req}, 32'h1);
    checkOutput("kill c2 addr", imem_addr, 32'h0);
    checkOutput("kill c2 valid", {31'b0, inst_valid}, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("kill c3 addr", imem_addr, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("kill c4 valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("kill c4 addr", imem_addr, 32'h100);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("kill c5 valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("kill c5 pc", inst_pc, 32'h100);
    checkOutput("kill c5 data", inst_data, memFunc(32'h100));
    step();

    $display("[TB] reset asserted with a request outstanding");
    imem_ack = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid req", {31'b0, imem_req}, 32'h0);
    checkOutput("rstmid valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("rstmid addr", imem_addr, RESET_PC);
    checkOutput("rstmid pc", inst_pc, 32'h0);
    resetDut(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rstmid c0 req", {31'b0, imem_req}, 32'h0);
    checkOutput("rstmid c0 valid", {31'b0, inst_valid}, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rstmid c1 req", {31'b0, imem_req}, 32'h1);
    checkOutput("rstmid c1 addr", imem_addr, RESET_PC);
    checkOutput("rstmid c1 valid", {31'b0, inst_valid}, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstmid c2 valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("rstmid c2 pc", inst_pc, RESET_PC);

`ifdef FETCH_PERF_EN
    $display("[TB] stall counter with two-cycle ack delay");
    resetDut(1'b0);
    modelReset();
    reqAge = 0;
    for (int i = 0; i < 40; i++) begin
      a = imem_req && (reqAge == 2);
      if (imem_req && !a) reqAge++;
      else reqAge = 0;
      modelCycle(a, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("perf nonzero", {31'b0, (perf_stall_cnt > 32'd20)}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("perf rst cnt", perf_stall_cnt, 32'h0);
    checkOutput("perf rst req", {31'b0, imem_req}, 32'h0);
`endif

    $display("[TB] randomized run against reference model");
    resetDut(1'b0);
    modelReset();
    for (int i = 0; i < 1500; i++) begin
      a = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) p = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      else p = $urandom;
      modelCycle(a, r, d, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
